// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N_REQ req/ack clients.
// Optional grant lock port is enabled by defining RAM_ARB_LOCK_EN.
module ram_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]         lock,
`endif
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [ID_W-1:0]          gnt_id,
  output logic                     ram_wr,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nx;
  logic [ID_W-1:0]     rr_ptr, ptr_nx;
  logic [ID_W-1:0]     gnt_nx;
  logic [N_REQ-1:0]    ack_nx;
  logic [DATA_W-1:0]   rdata_nx;
  logic                wr_q, wr_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   wdata_nx;
  logic [N_REQ-1:0]    eligible;
  logic                hold;
  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     idx;

  assign busy = (state == ACCESS);
  // Gating with rst keeps an aborted write from committing at the reset edge.
  assign ram_wr = wr_q & ~rst;

  always_comb begin
    state_nx = state;
    ptr_nx   = rr_ptr;
    gnt_nx   = gnt_id;
    ack_nx   = '0;
    rdata_nx = rdata;
    wr_nx    = 1'b0;
    addr_nx  = ram_addr;
    wdata_nx = ram_wdata;
    eligible = req & ~ack;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
`ifdef RAM_ARB_LOCK_EN
    hold     = (|ack) && lock[gnt_id] && req[gnt_id];
`else
    hold     = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (hold) begin
          found = 1'b1;
          win   = gnt_id;
        end else begin
          for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((32'(rr_ptr) + i) % N_REQ);
            if (!found && eligible[idx]) begin
              found = 1'b1;
              win   = idx;
            end
          end
        end
        if (found) begin
          state_nx = ACCESS;
          addr_nx  = addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_nx = wdata[int'(win)*DATA_W +: DATA_W];
          wr_nx    = we[win];
          gnt_nx   = win;
          if (!hold)
            ptr_nx = win;
        end
      end
      ACCESS: begin
        if (!wr_q)
          rdata_nx = ram_rdata;
        ack_nx[gnt_id] = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(N_REQ - 1);
      gnt_id    <= '0;
      ack       <= '0;
      rdata     <= '0;
      wr_q      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= ptr_nx;
      gnt_id    <= gnt_nx;
      ack       <= ack_nx;
      rdata     <= rdata_nx;
      wr_q      <= wr_nx;
      ram_addr  <= addr_nx;
      ram_wdata <= wdata_nx;
    end
  end

endmodule
